// File: rtl/ex_stage.sv
// core_lapido execute stage: ALU, 6-bit flag register, BEQ/BNE/JT/JF resolution, EX/MEM register.
// Define LAPIDO_EX_FLUSH_EN to squash the wrong-path instruction after a taken branch.
package lapido_ex_pkg;

  typedef enum logic [5:0] {
    FN_ADD  = 6'd0,
    FN_SUB  = 6'd1,
    FN_AND  = 6'd2,
    FN_OR   = 6'd3,
    FN_NOT  = 6'd4,
    FN_XOR  = 6'd5,
    FN_NOR  = 6'd6,
    FN_XNOR = 6'd7,
    FN_NAND = 6'd8,
    FN_LSL  = 6'd9,
    FN_LSR  = 6'd10,
    FN_ASL  = 6'd11,
    FN_ASR  = 6'd12,
    FN_SLT  = 6'd13
  } alu_funct_e;

  localparam int FL_TRUE     = 0;
  localparam int FL_ZERO     = 1;
  localparam int FL_NEG      = 2;
  localparam int FL_NEGZERO  = 3;
  localparam int FL_CARRY    = 4;
  localparam int FL_OVERFLOW = 5;

  localparam logic [5:0] FLAGS_RESET = 6'b000001;

endpackage

module ex_stage
  import lapido_ex_pkg::*;
#(
  parameter int GPR_WIDTH = 32,
  parameter int PC_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           alu_funct,
  input  logic                 alu_src_mux,
  input  logic [1:0]           reg_dst_mux,
  input  logic                 is_load,
  input  logic                 mem_write_enable,
  input  logic                 reg_write_enable,
  input  logic                 fl_write_enable,
  input  logic [1:0]           wb_res_mux,
  input  logic                 is_branch,
  input  logic                 sel_jflag_branch,
  input  logic                 sel_beq_bne,
  input  logic                 sel_jt_jf,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic [GPR_WIDTH-1:0] imm,
  input  logic [GPR_WIDTH-1:0] data_rs,
  input  logic [GPR_WIDTH-1:0] data_rt,
  input  logic [PC_WIDTH-1:0]  next_pc,
  output logic [PC_WIDTH-1:0]  branch_addr,
  output logic                 branch_taken,
  output logic [GPR_WIDTH-1:0] out_alu_result,
  output logic [GPR_WIDTH-1:0] out_data_rt,
  output logic [4:0]           out_dst,
  output logic                 out_is_load,
  output logic                 out_mem_write_enable,
  output logic                 out_reg_write_enable,
  output logic [1:0]           out_wb_res_mux,
  output logic [PC_WIDTH-1:0]  out_next_pc,
  output logic [5:0]           out_flags
);

  localparam int MSB = GPR_WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Operands and arithmetic
  // ---------------------------------------------------------------------------
  logic [GPR_WIDTH-1:0] op_a;
  logic [GPR_WIDTH-1:0] op_b;
  logic [4:0]           shamt;
  logic [GPR_WIDTH:0]   add_ext;
  logic [GPR_WIDTH:0]   sub_ext;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic                 slt_bit;

  assign op_a  = data_rs;
  assign op_b  = alu_src_mux ? imm : data_rt;
  assign shamt = op_b[4:0];

  // Carry is bit GPR_WIDTH of the zero-extended sum/difference (a borrow for SUB).
  assign add_ext = {1'b0, op_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, op_a} - {1'b0, op_b};

  assign add_ovf = (op_a[MSB] == op_b[MSB]) && (add_ext[MSB] != op_a[MSB]);
  assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (sub_ext[MSB] != op_a[MSB]);
  assign slt_bit = $signed(op_a) < $signed(op_b);

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [GPR_WIDTH-1:0] alu_result;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic                 funct_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    alu_result  = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    funct_valid = 1'b1;
    case (alu_funct)
      FN_ADD: begin
        alu_result = add_ext[GPR_WIDTH-1:0];
        alu_carry  = add_ext[GPR_WIDTH];
        alu_ovf    = add_ovf;
      end
      FN_SUB: begin
        alu_result = sub_ext[GPR_WIDTH-1:0];
        alu_carry  = sub_ext[GPR_WIDTH];
        alu_ovf    = sub_ovf;
      end
      FN_AND:  alu_result = op_a & op_b;
      FN_OR:   alu_result = op_a | op_b;
      FN_NOT:  alu_result = ~op_a;
      FN_XOR:  alu_result = op_a ^ op_b;
      FN_NOR:  alu_result = ~(op_a | op_b);
      FN_XNOR: alu_result = ~(op_a ^ op_b);
      FN_NAND: alu_result = ~(op_a & op_b);
      FN_LSL:  alu_result = op_a << shamt;
      FN_ASL:  alu_result = op_a << shamt;
      FN_LSR:  alu_result = op_a >> shamt;
      FN_ASR:  alu_result = $signed(op_a) >>> shamt;
      FN_SLT:  alu_result = {{(GPR_WIDTH-1){1'b0}}, slt_bit};
      default: funct_valid = 1'b0;
    endcase
  end

  logic [5:0] flags_new;

  always_comb begin
    flags_new               = '0;
    flags_new[FL_TRUE]      = 1'b1;
    flags_new[FL_ZERO]      = ~|alu_result;
    flags_new[FL_NEG]       = alu_result[MSB];
    flags_new[FL_NEGZERO]   = flags_new[FL_ZERO] | flags_new[FL_NEG];
    flags_new[FL_CARRY]     = alu_carry;
    flags_new[FL_OVERFLOW]  = alu_ovf;
  end

  // ---------------------------------------------------------------------------
  // Squash tracking
  // ---------------------------------------------------------------------------
  logic squash_pending;
  logic squash;

  assign squash = squash_pending;

`ifdef LAPIDO_EX_FLUSH_EN
  // A stall bubble carries no work, so the pending squash waits for a real instruction.
  logic id_bubble;

  assign id_bubble = ~(is_load | mem_write_enable | reg_write_enable |
                       fl_write_enable | is_branch);

  always_ff @(posedge clk) begin
    if (!rst) begin
      squash_pending <= 1'b0;
    end else if (squash_pending) begin
      squash_pending <= id_bubble;
    end else begin
      squash_pending <= branch_taken;
    end
  end
`else
  assign squash_pending = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Branch resolution (combinational, uses flags held at the start of the cycle)
  // ---------------------------------------------------------------------------
  logic [7:0] flags_padded;
  logic       jflag_cond;
  logic       cmp_cond;
  logic       branch_cond;
  logic       unused_rs_hi;

  assign flags_padded = {2'b00, out_flags};
  assign jflag_cond   = (rs[2:0] <= 3'd5) && (flags_padded[rs[2:0]] ^ sel_jt_jf);
  assign cmp_cond     = (data_rs == data_rt) ^ sel_beq_bne;
  assign branch_cond  = sel_jflag_branch ? jflag_cond : cmp_cond;
  assign unused_rs_hi = ^rs[4:3];

  assign branch_taken = rst && is_branch && !squash && branch_cond;
  assign branch_addr  = next_pc + imm[PC_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Destination select
  // ---------------------------------------------------------------------------
  logic [4:0] dst;

  always_comb begin
    dst = rd;
    case (reg_dst_mux)
      2'd1:    dst = rt;
      2'd2:    dst = 5'd31;
      default: dst = rd;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EX/MEM pipeline register and flag register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      out_alu_result       <= '0;
      out_data_rt          <= '0;
      out_dst              <= '0;
      out_is_load          <= 1'b0;
      out_mem_write_enable <= 1'b0;
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= '0;
      out_next_pc          <= '0;
      out_flags            <= FLAGS_RESET;
    end else begin
      out_alu_result       <= alu_result;
      out_data_rt          <= data_rt;
      out_dst              <= dst;
      out_is_load          <= is_load & ~squash;
      out_mem_write_enable <= mem_write_enable & ~squash;
      out_reg_write_enable <= reg_write_enable & ~squash;
      out_wb_res_mux       <= wb_res_mux;
      out_next_pc          <= next_pc;
      if (fl_write_enable && funct_valid && !squash) begin
        out_flags <= flags_new;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expected EX/MEM values go through a scoreboard queue.
// Expectations for the wrong-path instruction follow LAPIDO_EX_FLUSH_EN.
module tb_ex_stage;
  import lapido_ex_pkg::*;

  localparam int GW = 32;
  localparam int PW = 16;

`ifdef LAPIDO_EX_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [5:0]    alu_funct;
  logic          alu_src_mux;
  logic [1:0]    reg_dst_mux;
  logic          is_load, mem_write_enable, reg_write_enable, fl_write_enable;
  logic [1:0]    wb_res_mux;
  logic          is_branch, sel_jflag_branch, sel_beq_bne, sel_jt_jf;
  logic [4:0]    rd, rs, rt;
  logic [GW-1:0] imm, data_rs, data_rt;
  logic [PW-1:0] next_pc;
  logic [PW-1:0] branch_addr;
  logic          branch_taken;
  logic [GW-1:0] out_alu_result, out_data_rt;
  logic [4:0]    out_dst;
  logic          out_is_load, out_mem_write_enable, out_reg_write_enable;
  logic [1:0]    out_wb_res_mux;
  logic [PW-1:0] out_next_pc;
  logic [5:0]    out_flags;

  ex_stage #(.GPR_WIDTH(GW), .PC_WIDTH(PW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .alu_funct            (alu_funct),
    .alu_src_mux          (alu_src_mux),
    .reg_dst_mux          (reg_dst_mux),
    .is_load              (is_load),
    .mem_write_enable     (mem_write_enable),
    .reg_write_enable     (reg_write_enable),
    .fl_write_enable      (fl_write_enable),
    .wb_res_mux           (wb_res_mux),
    .is_branch            (is_branch),
    .sel_jflag_branch     (sel_jflag_branch),
    .sel_beq_bne          (sel_beq_bne),
    .sel_jt_jf            (sel_jt_jf),
    .rd                   (rd),
    .rs                   (rs),
    .rt                   (rt),
    .imm                  (imm),
    .data_rs              (data_rs),
    .data_rt              (data_rt),
    .next_pc              (next_pc),
    .branch_addr          (branch_addr),
    .branch_taken         (branch_taken),
    .out_alu_result       (out_alu_result),
    .out_data_rt          (out_data_rt),
    .out_dst              (out_dst),
    .out_is_load          (out_is_load),
    .out_mem_write_enable (out_mem_write_enable),
    .out_reg_write_enable (out_reg_write_enable),
    .out_wb_res_mux       (out_wb_res_mux),
    .out_next_pc          (out_next_pc),
    .out_flags            (out_flags)
  );

  typedef struct packed {
    logic [5:0]    funct;
    logic          src;
    logic [1:0]    dmux;
    logic          ld, mw, rw, fw;
    logic [1:0]    wb;
    logic          br, jflag, bne, jf;
    logic [4:0]    rd, rs, rt;
    logic [GW-1:0] imm, a, b;
    logic [PW-1:0] npc;
  } instr_t;

  typedef struct packed {
    logic          care;
    logic [GW-1:0] result, data_rt;
    logic [4:0]    dst;
    logic          ld, mw, rw;
    logic [1:0]    wb;
    logic [PW-1:0] npc;
    logic [5:0]    flags;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic exp_t pass(input instr_t i, input logic [GW-1:0] res,
                                input logic [4:0] dst, input logic [5:0] fl, input logic sq);
    exp_t e;
    e.care    = ~sq;
    e.result  = res;
    e.data_rt = i.b;
    e.dst     = dst;
    e.ld      = i.ld & ~sq;
    e.mw      = i.mw & ~sq;
    e.rw      = i.rw & ~sq;
    e.wb      = i.wb;
    e.npc     = i.npc;
    e.flags   = fl;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e       = '0;
    e.care  = 1'b1;
    e.flags = 6'b000001;
    return e;
  endfunction

  task automatic drive(input instr_t i);
    alu_funct        = i.funct;
    alu_src_mux      = i.src;
    reg_dst_mux      = i.dmux;
    is_load          = i.ld;
    mem_write_enable = i.mw;
    reg_write_enable = i.rw;
    fl_write_enable  = i.fw;
    wb_res_mux       = i.wb;
    is_branch        = i.br;
    sel_jflag_branch = i.jflag;
    sel_beq_bne      = i.bne;
    sel_jt_jf        = i.jf;
    rd               = i.rd;
    rs               = i.rs;
    rt               = i.rt;
    imm              = i.imm;
    data_rs          = i.a;
    data_rt          = i.b;
    next_pc          = i.npc;
  endtask

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at the falling edge, check branch outputs mid-cycle,
  // then check the EX/MEM register just after the next rising edge.
  task automatic run(input string tag, input instr_t i, input exp_t e,
                     input logic t_exp, input logic [PW-1:0] a_exp);
    exp_t got;
    drive(i);
    sb.push_back(e);
    #1;
    check({tag, "_taken"}, GW'(branch_taken), GW'(t_exp));
    if (i.br) check({tag, "_addr"}, GW'(branch_addr), GW'(a_exp));
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, "_flags"}, GW'(out_flags), GW'(got.flags));
    check({tag, "_rw"}, GW'(out_reg_write_enable), GW'(got.rw));
    check({tag, "_ld"}, GW'(out_is_load), GW'(got.ld));
    check({tag, "_mw"}, GW'(out_mem_write_enable), GW'(got.mw));
    if (got.care) begin
      check({tag, "_result"}, out_alu_result, got.result);
      check({tag, "_data_rt"}, out_data_rt, got.data_rt);
      check({tag, "_dst"}, GW'(out_dst), GW'(got.dst));
      check({tag, "_wb"}, GW'(out_wb_res_mux), GW'(got.wb));
      check({tag, "_npc"}, GW'(out_next_pc), GW'(got.npc));
    end
    @(negedge clk);
  endtask

  initial begin
    instr_t i;
    rst = 1'b0;
    drive(nop());
    @(negedge clk);

    // Reset with a would-be-taken BEQ on the inputs.
    i = nop(); i.br = 1'b1; i.rw = 1'b1; i.a = 32'd9; i.b = 32'd9;
    run("reset", i, rst_exp(), 1'b0, 16'd0);
    rst = 1'b1;

    i = nop(); i.funct = FN_ADD; i.a = 32'h7FFF_FFFF; i.b = 32'd1; i.rd = 5'd3; i.rw = 1'b1; i.fw = 1'b1;
    run("add_ovf", i, pass(i, 32'h8000_0000, 5'd3, 6'b101101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_SUB; i.a = 32'd5; i.b = 32'd5; i.rd = 5'd4; i.rw = 1'b1; i.fw = 1'b1;
    run("sub_zero", i, pass(i, 32'd0, 5'd4, 6'b001011, 1'b0), 1'b0, 16'd0);

    i = nop(); i.br = 1'b1; i.jflag = 1'b1; i.rs = 5'd1; i.npc = 16'd10; i.imm = 32'hFFFF_FFFD;
    run("jt_zero", i, pass(i, 32'd0, 5'd0, 6'b001011, 1'b0), 1'b1, 16'd7);

    i = nop(); i.src = 1'b1; i.dmux = 2'd1; i.imm = 32'd10; i.a = 32'd1; i.b = 32'h55; i.rt = 5'd7; i.rw = 1'b1;
    run("addi_after_jt", i, pass(i, 32'd11, 5'd7, 6'b001011, FLUSH), 1'b0, 16'd0);

    i = nop(); i.br = 1'b1; i.jflag = 1'b1; i.jf = 1'b1; i.rs = 5'd1; i.npc = 16'd10; i.imm = 32'hFFFF_FFFD;
    run("jf_zero", i, pass(i, 32'd0, 5'd0, 6'b001011, 1'b0), 1'b0, 16'd7);

    i = nop(); i.br = 1'b1; i.bne = 1'b1; i.a = 32'd4; i.b = 32'd4; i.npc = 16'd20; i.imm = 32'd4;
    run("bne_equal", i, pass(i, 32'd8, 5'd0, 6'b001011, 1'b0), 1'b0, 16'd24);

    i = nop(); i.br = 1'b1; i.a = 32'd4; i.b = 32'd4; i.npc = 16'd30; i.imm = 32'd5;
    run("beq_equal", i, pass(i, 32'd8, 5'd0, 6'b001011, 1'b0), 1'b1, 16'd35);

    i = nop();
    run("stall_bubble", i, pass(i, 32'd0, 5'd0, 6'b001011, 1'b0), 1'b0, 16'd0);

    i = nop(); i.src = 1'b1; i.dmux = 2'd1; i.imm = 32'd2; i.a = 32'd3; i.rt = 5'd8; i.rw = 1'b1;
    run("addi_after_beq", i, pass(i, 32'd5, 5'd8, 6'b001011, FLUSH), 1'b0, 16'd0);

    i = nop(); i.a = 32'd2; i.b = 32'd3; i.rd = 5'd9; i.rw = 1'b1; i.fw = 1'b1;
    run("add_after", i, pass(i, 32'd5, 5'd9, 6'b000001, 1'b0), 1'b0, 16'd0);

    i = nop(); i.dmux = 2'd2; i.npc = 16'd21; i.rw = 1'b1; i.wb = 2'd2; i.rd = 5'd5;
    run("jal_link", i, pass(i, 32'd0, 5'd31, 6'b000001, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = 6'h3F; i.a = 32'd5; i.b = 32'd5; i.rd = 5'd6; i.rw = 1'b1; i.fw = 1'b1;
    run("bad_funct", i, pass(i, 32'd0, 5'd6, 6'b000001, 1'b0), 1'b0, 16'd0);

    i = nop(); i.a = 32'hFFFF_FFFF; i.b = 32'd1; i.rd = 5'd10; i.rw = 1'b1; i.fw = 1'b1;
    run("add_carry", i, pass(i, 32'd0, 5'd10, 6'b011011, 1'b0), 1'b0, 16'd0);

    // Branch on old CARRY=1 while the same instruction's SUB clears it.
    i = nop(); i.funct = FN_SUB; i.a = 32'd6; i.b = 32'd6; i.fw = 1'b1;
    i.br = 1'b1; i.jflag = 1'b1; i.rs = 5'd4; i.npc = 16'd50; i.imm = 32'd2;
    run("jt_old_flags", i, pass(i, 32'd0, 5'd0, 6'b001011, 1'b0), 1'b1, 16'd52);

    rst = 1'b0;
    i = nop();
    run("reset_after_branch", i, rst_exp(), 1'b0, 16'd0);
    rst = 1'b1;

    i = nop(); i.a = 32'd7; i.b = 32'd8; i.rd = 5'd11; i.rw = 1'b1;
    run("first_after_reset", i, pass(i, 32'd15, 5'd11, 6'b000001, 1'b0), 1'b0, 16'd0);

    i = nop(); i.br = 1'b1; i.jflag = 1'b1; i.jf = 1'b1; i.rs = 5'd6; i.npc = 16'd60; i.imm = 32'd1;
    run("jf_code6", i, pass(i, 32'd0, 5'd0, 6'b000001, 1'b0), 1'b0, 16'd61);

    i = nop(); i.funct = FN_LSR; i.src = 1'b1; i.imm = 32'd4; i.a = 32'h8000_0000; i.rd = 5'd12;
    i.rw = 1'b1; i.ld = 1'b1; i.wb = 2'd1;
    run("lsr", i, pass(i, 32'h0800_0000, 5'd12, 6'b000001, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_ASR; i.src = 1'b1; i.imm = 32'd4; i.a = 32'h8000_0000; i.rd = 5'd13; i.fw = 1'b1;
    run("asr", i, pass(i, 32'hF800_0000, 5'd13, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_ASL; i.a = 32'd1; i.b = 32'h0000_003F; i.mw = 1'b1;
    run("asl_31", i, pass(i, 32'h8000_0000, 5'd0, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_SLT; i.a = 32'hFFFF_FFFF; i.b = 32'd1; i.rd = 5'd14; i.rw = 1'b1;
    run("slt_neg", i, pass(i, 32'd1, 5'd14, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_SLT; i.a = 32'd1; i.b = 32'hFFFF_FFFF; i.rd = 5'd14; i.rw = 1'b1;
    run("slt_pos", i, pass(i, 32'd0, 5'd14, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_XNOR; i.a = 32'hF0F0_F0F0; i.b = 32'hFF00_FF00;
    run("xnor", i, pass(i, 32'hF00F_F00F, 5'd0, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_NAND; i.a = 32'hF0F0_F0F0; i.b = 32'hFF00_FF00;
    run("nand", i, pass(i, 32'h0FFF_0FFF, 5'd0, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_NOT; i.a = 32'h0000_FFFF; i.b = 32'h1234_5678;
    run("not", i, pass(i, 32'hFFFF_0000, 5'd0, 6'b001101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.funct = FN_SUB; i.a = 32'd3; i.b = 32'd5; i.fw = 1'b1;
    run("sub_borrow", i, pass(i, 32'hFFFF_FFFE, 5'd0, 6'b011101, 1'b0), 1'b0, 16'd0);

    i = nop(); i.br = 1'b1; i.jflag = 1'b1; i.rs = 5'd0; i.npc = 16'd100; i.imm = 32'hFFFF_FF9C;
    run("jt_true_wrap", i, pass(i, 32'd0, 5'd0, 6'b011101, 1'b0), 1'b1, 16'd0);

    check("scoreboard_empty", GW'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the core_lapido pipeline, directly downstream of `ID_stage`. It consumes the decoded control and operand bundle from ID, computes the ALU result, and maintains the 6-bit flag register. It resolves BEQ/BNE/JT/JF, drives `branch_addr`/`branch_taken` back to `IF_stage`, and registers everything the MEM/WB stages need into the EX/MEM pipeline register.

## Interface
Parameters (widths come from `lapido_defs.v`):
- `GPR_WIDTH`, 32, data path width
- `PC_WIDTH`, from defs, word-addressed PC width

Ports:
- clk  in  1  clock; every state element updates on the rising edge
- rst  in  1  one clock; reset is synchronous and active-low
- alu_funct  in  6  `FN_*` operation code from ID
- alu_src_mux  in  1  operand B select: 0 = data_rt, 1 = imm
- reg_dst_mux  in  2  dest select: 0 = rd, 1 = rt, 2 = r31 (JAL link); 3 = rd
- is_load, mem_write_enable, reg_write_enable, fl_write_enable  in  1 each  control from ID
- wb_res_mux  in  2  WB source select, passed through
- is_branch, sel_jflag_branch, sel_beq_bne, sel_jt_jf  in  1 each  branch control
- rd, rs, rt  in  5 each  register fields; `rs` is the flag code for JT/JF
- imm, data_rs, data_rt  in  GPR_WIDTH  sign-extended immediate and operands
- next_pc  in  PC_WIDTH  PC+1 of the instruction in EX
- branch_addr  out  PC_WIDTH  next_pc + imm[PC_WIDTH-1:0], combinational
- branch_taken  out  1  combinational branch resolution
- out_alu_result, out_data_rt  out  GPR_WIDTH  registered
- out_dst  out  5  registered destination register
- out_is_load, out_mem_write_enable, out_reg_write_enable  out  1  registered
- out_wb_res_mux  out  2  registered
- out_next_pc  out  PC_WIDTH  registered (JAL link value)
- out_flags  out  6  flag register

## Operation
- Operand A = data_rs. Operand B = imm when alu_src_mux=1, else data_rt.
- ALU ops:
  - ADD, SUB, AND, OR, NOT(A), XOR, NOR, XNOR, NAND.
  - LSL/LSR/ASL/ASR shift A by B[4:0]. ASL is identical to LSL.
  - SLT is signed; result is 1 or 0.
  - Any unlisted funct: result 0, and the flag write is suppressed.
- Flags, bit index:
  - 0 TRUE, always 1.
  - 1 ZERO: result == 0.
  - 2 NEG: result[31].
  - 3 NEGZERO: NEG or ZERO.
  - 4 CARRY: bit 32 of the 33-bit ADD/SUB; 0 for other ops.
  - 5 OVERFLOW: signed overflow of ADD/SUB; 0 for other ops.
- The flag register loads at the clock edge when fl_write_enable=1 and the cycle is not squashed.
- Branch condition, applied when is_branch=1:
  - sel_jflag_branch=0: taken = (data_rs == data_rt) XOR sel_beq_bne, where sel_beq_bne=1 means BNE.
  - sel_jflag_branch=1: taken = flags[rs[2:0]] XOR sel_jt_jf, where sel_jt_jf=1 means JF.
  - rs[2:0] > 5 is never taken.
- JT/JF read the flag register value as held at the start of the cycle. A flag-writing instruction immediately ahead is already committed.
- out_dst follows reg_dst_mux.
- Squash: a squashed cycle registers bubble controls (all write enables and is_load = 0, other fields don't-care) and forces branch_taken=0.

## Timing
- Branch resolution is combinational, so the IF redirect happens on the next edge.
- EX/MEM register latency is 1 cycle.
- Flags are visible on out_flags and to JT/JF the cycle after the write.
- Reset, sampled at the edge with rst=0:
  - all out_* = 0
  - out_flags = 6'b000001
  - squash_pending = 0
  - branch_taken is forced to 0 while rst=0
- Reset mid-branch clears squash_pending, so no stale squash survives reset.
- The ID stall bubble (all enables 0) passes through as a NOP; it does not clear squash_pending.
- Simultaneous fl_write_enable and is_branch: the branch uses the old flags and the write still commits.

## Configuration
- `LAPIDO_EX_FLUSH_EN` defined:
  - A taken branch sets squash_pending at the edge.
  - The next instruction arriving from ID (the wrong-path instruction) is squashed, and squash_pending clears.
  - A squashed branch cannot take.
- Undefined:
  - No squash logic; the instruction after a branch executes normally (delay-slot semantics).
  - squash_pending is tied to 0.

## Test plan
- ADD with data_rs=32'h7FFFFFFF, data_rt=1, fl_write_enable=1 -> next cycle out_alu_result=32'h80000000; flags NEG=1, OVERFLOW=1, CARRY=0, ZERO=0, TRUE=1.
- SUB with data_rs = data_rt = 5, then JT with rs=1, next_pc=10, imm=-3 -> on the JT cycle branch_taken=1, branch_addr=7. Repeat with JF -> branch_taken=0.
- BNE with data_rs=4, data_rt=4 -> branch_taken=0. Same operands with BEQ -> branch_taken=1.
- Flush enabled: BEQ taken followed by ADDI with reg_write_enable=1 -> the ADDI registers out_reg_write_enable=0, and the instruction after it executes normally. Flush disabled: the ADDI registers out_reg_write_enable=1.
- JAL with reg_dst_mux=2, next_pc=21 -> out_dst=31, out_next_pc=21, out_reg_write_enable=1.
- rst=0 asserted in the cycle after a taken branch -> all outputs 0, flags=6'b000001. After release, the first instruction is not squashed.
